butterfly_pipe: RTL
===================

Name: butterfly_pipe

Overview:
Pipelined, parametrised radix-2 DIT butterfly for the FFT datapath: A' = A + B·W, B' = A − B·W.
- Adds over the existing combinational butterfly: valid/ready streaming with backpressure, fixed-point twiddle rounding, optional per-operation divide-by-2 scaling, inverse-transform mode (conjugate twiddle), saturation, and a sticky overflow flag.
- Sits between the FFT address/twiddle sequencer and the ping-pong sample RAMs.

Parameters:
- DATA_W, 16, signed width of A/B inputs and A'/B' outputs.
- TW_W, 16, signed width of twiddle components.
- TW_FRAC, 15, fractional bits of twiddle (Q1.TW_FRAC); must be < TW_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand set valid.
- in_ready  out  1  block can accept an operand set this cycle.
- real_a, img_a  in  DATA_W each  operand A, signed.
- real_b, img_b  in  DATA_W each  operand B, signed.
- real_tw, img_tw  in  TW_W each  twiddle W, signed Q1.TW_FRAC.
- scale  in  1  per-operation: 1 = divide both outputs by 2 with rounding.
- inverse  in  1  per-operation: 1 = use conj(W).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- real_ap, img_ap, real_bp, img_bp  out  DATA_W each  A', B', signed.
- ovf  out  1  sticky: a saturation occurred since last clear.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset: all pipeline valid bits = 0, out_valid = 0, all data outputs = 0, ovf = 0. in_ready = 1 from the first cycle after reset.
- While reset is high: in_valid is ignored. A reset asserted mid-operation discards all in-flight operations; no result is emitted for them.
- Pipeline: 3 register stages, latency 3 cycles. An operation accepted on edge N appears on out_valid after edge N+3 if there is no stall.
  - S1: register operands, scale, inverse.
  - S2: register the four products br·twr, bi·twi, br·twi, bi·twr, each full width DATA_W+TW_W.
  - S3: combine, round, add/sub, scale, saturate; register the outputs.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - stall = out_valid && !out_ready. A stall freezes all stages, and in_ready = !stall.
  - Output data and out_valid hold stable during a stall.
  - Bubbles propagate: no compaction is required.
  - Throughput is 1 op/cycle with out_ready held high.
- Complex product:
  - Forward (inverse = 0): re = br·twr − bi·twi; im = br·twi + bi·twr.
  - Inverse (inverse = 1): re = br·twr + bi·twi; im = bi·twr − br·twi. No twiddle negation, so −2^(TW_W−1) is safe.
  - Computed at DATA_W+TW_W+1 bits.
  - Rounding: add 2^(TW_FRAC−1), then arithmetic shift right by TW_FRAC (round half up). Result held at DATA_W+2 bits: btw_re, btw_im.
- Sums:
  - sa = a + btw; sb = a − btw, at DATA_W+3 bits.
  - If scale = 1: s = (s + 1) >>> 1.
- Saturation:
  - Clamp each of the 4 results to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Any clamp sets ovf on the S3 load edge.
- ovf_clr:
  - When high, ovf is cleared.
  - A simultaneous clamp on the same edge wins: ovf ends at 1.
  - ovf does not change during a stall.

Test Plan:
- Reset then idle: out_valid = 0, all data outputs = 0, ovf = 0, in_ready = 1.
- Unity twiddle: a = (1000, 0), b = (200, 0), tw = (32767, 0), scale = 0, inverse = 0 → 3 cycles later A' = (1200, 0), B' = (800, 0).
- −j twiddle:
  - a = (0, 0), b = (200, 100), tw = (0, −32768) → A' = (100, −200), B' = (−100, 200).
  - Same operands with inverse = 1 → A' = (−100, 200).
- Saturation and scale:
  - a = b = (32000, 0), tw = (32767, 0), scale = 0 → A' = (32767, 0), B' = (1, 0), ovf = 1.
  - Same with scale = 1 → A' = (32000, 0), B' = (1, 0), ovf unchanged.
  - Assert ovf_clr → ovf = 0.
- Backpressure: stream 8 ops with out_ready toggling 1,0,0,1,… → results in order with none lost or duplicated; in_ready = 0 exactly on stall cycles; outputs stable while stalled.
- Reset mid-stream: 3 ops in flight, then pulse reset for 1 cycle → out_valid stays 0 until the next accepted op, which emits exactly 3 cycles later.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly A' = A + B*W, B' = A - B*W with rounding, optional /2, conj-twiddle and saturation.
// Latency 3 cycles, 1 op/cycle; any output stall (out_valid && !out_ready) freezes every stage and drops in_ready.
module butterfly_pipe #(
  parameter int DATA_W  = 16,
  parameter int TW_W    = 16,
  parameter int TW_FRAC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] real_a,
  input  logic [DATA_W-1:0] img_a,
  input  logic [DATA_W-1:0] real_b,
  input  logic [DATA_W-1:0] img_b,
  input  logic [TW_W-1:0]   real_tw,
  input  logic [TW_W-1:0]   img_tw,
  input  logic              scale,
  input  logic              inverse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] real_ap,
  output logic [DATA_W-1:0] img_ap,
  output logic [DATA_W-1:0] real_bp,
  output logic [DATA_W-1:0] img_bp,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int PW = DATA_W + TW_W;
  localparam int CW = PW + 1;
  localparam int BW = DATA_W + 2;
  localparam int SW = DATA_W + 3;

  localparam logic signed [CW-1:0] RND  = CW'(1) << (TW_FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(1 << (DATA_W - 1)));

  logic stall;
  logic v1, v2, v3;

  logic signed [DATA_W-1:0] a_re1, a_im1, b_re1, b_im1;
  logic signed [TW_W-1:0]   tw_re1, tw_im1;
  logic                     scale1, inv1;

  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_W-1:0] a_re2, a_im2;
  logic                     scale2, inv2;

  logic signed [CW-1:0]     c_re, c_im;
  logic signed [BW-1:0]     btw_re, btw_im;
  logic signed [SW-1:0]     sa_re, sa_im, sb_re, sb_im;
  logic                     any_clip;

  logic signed [DATA_W-1:0] ap_re_q, ap_im_q, bp_re_q, bp_im_q;

  function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] v, input logic s);
    logic signed [SW-1:0] r;
    r = s ? ((v + SW'(1)) >>> 1) : v;
    return r;
  endfunction

  function automatic logic clips(input logic signed [SW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > MAXV)      r = MAXV[DATA_W-1:0];
    else if (v < MINV) r = MINV[DATA_W-1:0];
    else               r = v[DATA_W-1:0];
    return r;
  endfunction

  assign stall     = v3 && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v3;

  // Datapath registers carry no reset: the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (in_valid) begin
        a_re1  <= $signed(real_a);
        a_im1  <= $signed(img_a);
        b_re1  <= $signed(real_b);
        b_im1  <= $signed(img_b);
        tw_re1 <= $signed(real_tw);
        tw_im1 <= $signed(img_tw);
        scale1 <= scale;
        inv1   <= inverse;
      end
      if (v1) begin
        p_rr   <= PW'(b_re1) * PW'(tw_re1);
        p_ii   <= PW'(b_im1) * PW'(tw_im1);
        p_ri   <= PW'(b_re1) * PW'(tw_im1);
        p_ir   <= PW'(b_im1) * PW'(tw_re1);
        a_re2  <= a_re1;
        a_im2  <= a_im1;
        scale2 <= scale1;
        inv2   <= inv1;
      end
    end
  end

  // Conjugation is folded into the add/sub signs so a -2^(TW_W-1) twiddle never needs negating.
  always_comb begin
    if (inv2) begin
      c_re = CW'(p_rr) + CW'(p_ii);
      c_im = CW'(p_ir) - CW'(p_ri);
    end else begin
      c_re = CW'(p_rr) - CW'(p_ii);
      c_im = CW'(p_ri) + CW'(p_ir);
    end
    btw_re   = BW'((c_re + RND) >>> TW_FRAC);
    btw_im   = BW'((c_im + RND) >>> TW_FRAC);
    sa_re    = halve(SW'(a_re2) + SW'(btw_re), scale2);
    sa_im    = halve(SW'(a_im2) + SW'(btw_im), scale2);
    sb_re    = halve(SW'(a_re2) - SW'(btw_re), scale2);
    sb_im    = halve(SW'(a_im2) - SW'(btw_im), scale2);
    any_clip = clips(sa_re) || clips(sa_im) || clips(sb_re) || clips(sb_im);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      ovf     <= 1'b0;
      ap_re_q <= '0;
      ap_im_q <= '0;
      bp_re_q <= '0;
      bp_im_q <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (v2) begin
        ap_re_q <= sat(sa_re);
        ap_im_q <= sat(sa_im);
        bp_re_q <= sat(sb_re);
        bp_im_q <= sat(sb_im);
      end
      ovf <= (v2 && any_clip) || (ovf && !ovf_clr);
    end
  end

  assign real_ap = ap_re_q;
  assign img_ap  = ap_im_q;
  assign real_bp = bp_re_q;
  assign img_bp  = bp_im_q;

endmodule
